// File: rtl/dmawr_tlp_splitter.sv
`default_nettype none
// ============================================================================
// Module      : dmawr_tlp_splitter
// Description : Splits a DMA write command (address + byte count) into PCIe
//               memory-write requests bounded by the max payload size and by
//               4 KB address boundaries. One command at a time, at most one
//               request per clock, all outputs registered.
// Revision    : 1.0 - initial release
// ============================================================================
module dmawr_tlp_splitter #(
    parameter int ADDR_WIDTH = 64,
    parameter int BCNT_WIDTH = 24
) (
    input  logic                  sysclk,
    input  logic                  sysrst,
    input  logic [2:0]            cfg_max_payload,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [BCNT_WIDTH-1:0] cmd_bcnt,
    input  logic                  cmd_eof,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [7:0]            req_dwcnt,
    output logic                  req_first,
    output logic                  req_last,
    output logic                  req_eof,
    output logic                  busy,
    output logic                  err_zero_bcnt,
    output logic [31:0]           tlp_count,
    input  logic                  cnt_clr
);

    // Remaining-length register is kept in DWORDs.
    localparam int RW = BCNT_WIDTH - 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  req_valid_q, req_valid_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [7:0]            req_dwcnt_q, req_dwcnt_d;
    logic                  req_first_q, req_first_d;
    logic                  req_last_q, req_last_d;
    logic                  req_eof_q, req_eof_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic [31:0]           tlp_cnt_q, tlp_cnt_d;
    logic [RW-1:0]         rem_q, rem_d;
    logic                  eof_q, eof_d;
    logic [7:0]            mps_q, mps_d;

    logic                  cmd_hs;
    logic                  req_hs;
    logic [RW-1:0]         cmd_dw;
    logic [7:0]            mps_dec;
    logic [ADDR_WIDTH-1:0] calc_addr;
    logic [RW-1:0]         calc_rem;
    logic [7:0]            calc_mps;
    logic [10:0]           gap_dw;
    logic [7:0]            lim_dw;
    logic [7:0]            chunk;
    logic                  chunk_last;
    logic                  load;
    logic                  first_next;
    logic                  zero_set;
    logic                  unused_bits;

    // Address and byte-count low bits carry no meaning at DWORD granularity.
    assign unused_bits = ^{cmd_addr[1:0], cmd_bcnt[1:0]};

    assign cmd_hs = cmd_valid && cmd_ready_q;
    assign req_hs = req_valid_q && req_ready;
    assign cmd_dw = cmd_bcnt[BCNT_WIDTH-1:2];

    // Decode the payload limit into DWORDs; unknown encodings fall back to 128 B.
    always_comb begin
        case (cfg_max_payload)
            3'd1:    mps_dec = 8'd64;
            3'd2:    mps_dec = 8'd128;
            default: mps_dec = 8'd32;
        endcase
    end

    // Select the address/length the next request is cut from: the incoming
    // command while idle, otherwise the state after the current request.
    always_comb begin
        calc_addr = req_addr_q + {{(ADDR_WIDTH-10){1'b0}}, req_dwcnt_q, 2'b00};
        calc_rem  = rem_q - {{(RW-8){1'b0}}, req_dwcnt_q};
        calc_mps  = mps_q;
        if (state_q == IDLE) begin
            calc_addr = {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
            calc_rem  = cmd_dw;
            calc_mps  = mps_dec;
        end
    end

    // Chunk = min(remaining, mps, DWORDs left before the next 4 KB boundary).
    always_comb begin
        gap_dw = 11'd1024 - {1'b0, calc_addr[11:2]};
        if (gap_dw < {3'b000, calc_mps}) begin
            lim_dw = gap_dw[7:0];
        end else begin
            lim_dw = calc_mps;
        end
        if (calc_rem <= {{(RW-8){1'b0}}, lim_dw}) begin
            chunk      = calc_rem[7:0];
            chunk_last = 1'b1;
        end else begin
            chunk      = lim_dw;
            chunk_last = 1'b0;
        end
    end

    // Next-state logic: command capture, request advance and counters.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        req_dwcnt_d = req_dwcnt_q;
        req_first_d = req_first_q;
        req_last_d  = req_last_q;
        req_eof_d   = req_eof_q;
        busy_d      = busy_q;
        rem_d       = rem_q;
        eof_d       = eof_q;
        mps_d       = mps_q;
        load        = 1'b0;
        first_next  = 1'b0;
        zero_set    = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_hs) begin
                    if (cmd_dw == '0) begin
                        zero_set = 1'b1;
                    end else begin
                        state_d     = SPLIT;
                        cmd_ready_d = 1'b0;
                        busy_d      = 1'b1;
                        eof_d       = cmd_eof;
                        mps_d       = mps_dec;
                        load        = 1'b1;
                        first_next  = 1'b1;
                    end
                end
            end
            SPLIT: begin
                cmd_ready_d = 1'b0;
                if (req_hs) begin
                    if (req_last_q) begin
                        state_d     = IDLE;
                        req_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        cmd_ready_d = 1'b1;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            req_valid_d = 1'b1;
            req_addr_d  = calc_addr;
            req_dwcnt_d = chunk;
            req_first_d = first_next;
            req_last_d  = chunk_last;
            req_eof_d   = chunk_last && eof_d;
            rem_d       = calc_rem;
        end

        // A clear wins over both the zero-count flag and a counted request.
        if (cnt_clr) begin
            err_d = 1'b0;
        end else if (zero_set) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end

        if (cnt_clr) begin
            tlp_cnt_d = 32'd0;
        end else if (req_hs) begin
            tlp_cnt_d = tlp_cnt_q + 32'd1;
        end else begin
            tlp_cnt_d = tlp_cnt_q;
        end
    end

    // State register.
    always_ff @(posedge sysclk or posedge sysrst) begin
        if (sysrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output and datapath registers; reset discards any partial command.
    always_ff @(posedge sysclk or posedge sysrst) begin
        if (sysrst) begin
            cmd_ready_q <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_dwcnt_q <= 8'd0;
            req_first_q <= 1'b0;
            req_last_q  <= 1'b0;
            req_eof_q   <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            tlp_cnt_q   <= 32'd0;
            rem_q       <= '0;
            eof_q       <= 1'b0;
            mps_q       <= 8'd32;
        end else begin
            cmd_ready_q <= cmd_ready_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_dwcnt_q <= req_dwcnt_d;
            req_first_q <= req_first_d;
            req_last_q  <= req_last_d;
            req_eof_q   <= req_eof_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            tlp_cnt_q   <= tlp_cnt_d;
            rem_q       <= rem_d;
            eof_q       <= eof_d;
            mps_q       <= mps_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign req_valid     = req_valid_q;
    assign req_addr      = req_addr_q;
    assign req_dwcnt     = req_dwcnt_q;
    assign req_first     = req_first_q;
    assign req_last      = req_last_q;
    assign req_eof       = req_eof_q;
    assign busy          = busy_q;
    assign err_zero_bcnt = err_q;
    assign tlp_count     = tlp_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dmawr_tlp_splitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmawr_tlp_splitter
// Description : Self-checking bench for dmawr_tlp_splitter with a queue-based
//               reference model of the request split.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmawr_tlp_splitter;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  dw;
        logic        first;
        logic        last;
        logic        eof;
    } req_t;

    logic        sysclk = 1'b0;
    logic        sysrst = 1'b1;
    logic [2:0]  cfg_max_payload = 3'd0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [63:0] cmd_addr = 64'd0;
    logic [23:0] cmd_bcnt = 24'd0;
    logic        cmd_eof = 1'b0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [63:0] req_addr;
    logic [7:0]  req_dwcnt;
    logic        req_first;
    logic        req_last;
    logic        req_eof;
    logic        busy;
    logic        err_zero_bcnt;
    logic [31:0] tlp_count;
    logic        cnt_clr = 1'b0;

    int   n_cmp   = 0;
    int   n_fail  = 0;
    int   exp_tlp = 0;
    req_t exp_q[$];

    dmawr_tlp_splitter #(.ADDR_WIDTH(64), .BCNT_WIDTH(24)) dut (
        .sysclk(sysclk), .sysrst(sysrst), .cfg_max_payload(cfg_max_payload),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_bcnt(cmd_bcnt), .cmd_eof(cmd_eof), .req_valid(req_valid),
        .req_ready(req_ready), .req_addr(req_addr), .req_dwcnt(req_dwcnt),
        .req_first(req_first), .req_last(req_last), .req_eof(req_eof),
        .busy(busy), .err_zero_bcnt(err_zero_bcnt), .tlp_count(tlp_count),
        .cnt_clr(cnt_clr)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // Reference: walk the byte range, cutting at min(remaining, payload, 4 KB gap).
    task automatic build_model(input logic [63:0] a, input logic [23:0] b,
                               input logic e, input logic [2:0] m);
        logic [63:0] addr;
        int rem, mps, gap, c;
        bit first;
        addr  = {a[63:2], 2'b00};
        rem   = int'(b) / 4;
        mps   = (m == 3'd1) ? 64 : (m == 3'd2) ? 128 : 32;
        first = 1'b1;
        exp_q.delete();
        while (rem > 0) begin
            gap = (4096 - int'(addr % 64'd4096)) / 4;
            c = rem;
            if (mps < c) c = mps;
            if (gap < c) c = gap;
            exp_q.push_back('{addr: addr, dw: 8'(c), first: first,
                              last: (c == rem), eof: (c == rem) && e});
            addr  = addr + 64'(c * 4);
            rem   = rem - c;
            first = 1'b0;
        end
    endtask

    // mode 0: always ready, 1: random ready, 2: stall stall_n cycles then ready.
    // clr_at: request index whose handshake coincides with cnt_clr (-1 = none).
    task automatic run_cmd(input logic [63:0] a, input logic [23:0] b,
                           input logic e, input logic [2:0] m,
                           input int mode, input int stall_n, input int clr_at);
        req_t exp, snap;
        int   g, cyc, stall, hs_idx;
        bit   rdy, vld, clr;
        build_model(a, b, e, m);
        cfg_max_payload = m;
        cmd_addr  = a;
        cmd_bcnt  = b;
        cmd_eof   = e;
        cmd_valid = 1'b1;
        g = 0;
        while (!cmd_ready && g < 50) begin
            tick();
            g++;
        end
        n_cmp++;
        if (!cmd_ready) begin
            n_fail++;
            $display("FAIL cmd_ready_timeout: got %0b expected 1", cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        tick();
        cmd_valid = 1'b0;
        cfg_max_payload = 3'($urandom_range(0, 7));
        cmd_addr = {$urandom, $urandom};
        n_cmp++;
        if (req_valid !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL first_req_latency: got valid/busy/ready=%b%b%b expected 110",
                     req_valid, busy, cmd_ready);
            return;
        end
        cyc = 0; stall = 0; hs_idx = 0;
        while (exp_q.size() > 0 && cyc < 4000) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 99) < 70);
                default: begin
                    rdy = (stall >= stall_n);
                    if (!rdy) stall++;
                end
            endcase
            clr       = rdy && (hs_idx == clr_at);
            cnt_clr   = clr;
            req_ready = rdy;
            vld  = req_valid;
            snap = '{addr: req_addr, dw: req_dwcnt, first: req_first,
                     last: req_last, eof: req_eof};
            tick();
            cnt_clr = 1'b0;
            cyc++;
            if (mode == 1) cfg_max_payload = 3'($urandom_range(0, 7));
            if (!vld) begin
                n_cmp++;
                n_fail++;
                $display("FAIL req_valid_dropped: got 0 expected 1");
                break;
            end
            if (rdy) begin
                exp = exp_q.pop_front();
                hs_idx++;
                n_cmp++;
                if (snap !== exp) begin
                    n_fail++;
                    $display("FAIL req_fields: got %h/%0d f%b l%b e%b expected %h/%0d f%b l%b e%b",
                             snap.addr, snap.dw, snap.first, snap.last, snap.eof,
                             exp.addr, exp.dw, exp.first, exp.last, exp.eof);
                end
                exp_tlp = clr ? 0 : exp_tlp + 1;
                n_cmp++;
                if (tlp_count !== 32'(exp_tlp)) begin
                    n_fail++;
                    $display("FAIL tlp_count: got %0d expected %0d", tlp_count, exp_tlp);
                end
                if (!exp.last) begin
                    n_cmp++;
                    if (req_valid !== 1'b1) begin
                        n_fail++;
                        $display("FAIL back_to_back: got req_valid=%b expected 1", req_valid);
                    end
                end
            end else begin
                n_cmp++;
                if (req_valid !== 1'b1 || {req_addr, req_dwcnt, req_first, req_last, req_eof} !== snap) begin
                    n_fail++;
                    $display("FAIL hold_stable: got %b/%h/%0d expected 1/%h/%0d",
                             req_valid, req_addr, req_dwcnt, snap.addr, snap.dw);
                end
            end
        end
        req_ready = 1'b0;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL req_timeout: got %0d left expected 0", exp_q.size());
        end
        n_cmp++;
        if ({req_valid, cmd_ready, busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL end_of_cmd: got valid/ready/busy=%b%b%b expected 010",
                     req_valid, cmd_ready, busy);
        end
    endtask

    task automatic check_reset_values(input string name);
        n_cmp++;
        if ({cmd_ready, req_valid, req_addr, req_dwcnt, req_first, req_last,
             req_eof, busy, err_zero_bcnt, tlp_count} !== '0) begin
            n_fail++;
            $display("FAIL %s: got rdy%b vld%b addr%h dw%0d flags%b%b%b busy%b err%b cnt%0d expected all 0",
                     name, cmd_ready, req_valid, req_addr, req_dwcnt, req_first,
                     req_last, req_eof, busy, err_zero_bcnt, tlp_count);
        end
    endtask

    task automatic test_reset();
        sysrst = 1'b1;
        repeat (3) tick();
        check_reset_values("reset_values");
        sysrst = 1'b0;
        exp_tlp = 0;
        tick();
        n_cmp++;
        if (cmd_ready !== 1'b1 || req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got ready/valid=%b%b expected 10", cmd_ready, req_valid);
        end
    endtask

    task automatic test_mps_split();
        run_cmd(64'h1000, 24'd1024, 1'b0, 3'd1, 0, 0, -1);
    endtask

    task automatic test_4k_cross();
        run_cmd(64'h0FC0, 24'd256, 1'b1, 3'd2, 0, 0, -1);
    endtask

    task automatic test_carry_illegal_mps();
        run_cmd(64'h0_FFFF_FF80, 24'd256, 1'b0, 3'd3, 0, 0, -1);
    endtask

    task automatic test_backpressure();
        run_cmd(64'h1000, 24'd1024, 1'b1, 3'd1, 2, 5, -1);
    endtask

    task automatic test_zero_count();
        cmd_addr = 64'h2000; cmd_bcnt = 24'd3; cmd_eof = 1'b1; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        n_cmp++;
        if ({err_zero_bcnt, cmd_ready, req_valid, busy} !== 4'b1100) begin
            n_fail++;
            $display("FAIL zero_count: got err/rdy/vld/busy=%b%b%b%b expected 1100",
                     err_zero_bcnt, cmd_ready, req_valid, busy);
        end
        repeat (3) tick();
        n_cmp++;
        if (req_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_count_idle: got vld/rdy=%b%b expected 01", req_valid, cmd_ready);
        end
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        exp_tlp = 0;
        n_cmp++;
        if (err_zero_bcnt !== 1'b0 || tlp_count !== 32'd0) begin
            n_fail++;
            $display("FAIL cnt_clr: got err=%b cnt=%0d expected 0/0", err_zero_bcnt, tlp_count);
        end
    endtask

    task automatic test_cnt_clr_priority();
        // Clear on the 2nd handshake of a 4-request command: increment is lost.
        run_cmd(64'h3000, 24'd512, 1'b0, 3'd0, 0, 0, 1);
        cmd_bcnt = 24'd2; cmd_valid = 1'b1; cnt_clr = 1'b1;
        tick();
        cmd_valid = 1'b0; cnt_clr = 1'b0;
        exp_tlp = 0;
        n_cmp++;
        if (err_zero_bcnt !== 1'b0 || tlp_count !== 32'd0) begin
            n_fail++;
            $display("FAIL clr_over_zero_set: got err=%b cnt=%0d expected 0/0",
                     err_zero_bcnt, tlp_count);
        end
    endtask

    task automatic test_back_to_back();
        run_cmd(64'h4F00, 24'd600, 1'b1, 3'd2, 0, 0, -1);
        run_cmd(64'h5000, 24'd128, 1'b0, 3'd0, 0, 0, -1);
        run_cmd(64'h5FFC, 24'd8, 1'b1, 3'd1, 0, 0, -1);
    endtask

    task automatic test_random();
        logic [63:0] a;
        for (int i = 0; i < 30; i++) begin
            a = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) a[11:0] = 12'hFFF - 12'($urandom_range(0, 600));
            run_cmd(a, 24'($urandom_range(4, 6000)), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), 1, 0, -1);
        end
    endtask

    task automatic test_reset_mid();
        cfg_max_payload = 3'd0; cmd_addr = 64'h8000; cmd_bcnt = 24'd2048;
        cmd_eof = 1'b1; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        req_ready = 1'b1;
        repeat (3) tick();
        sysrst = 1'b1;
        #1;
        check_reset_values("reset_mid_cmd");
        tick();
        sysrst = 1'b0;
        exp_tlp = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (req_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_quiet: got vld/busy=%b%b expected 00", req_valid, busy);
            end
        end
        req_ready = 1'b0;
        n_cmp++;
        if (cmd_ready !== 1'b1 || tlp_count !== 32'd0) begin
            n_fail++;
            $display("FAIL post_reset_state: got rdy=%b cnt=%0d expected 1/0", cmd_ready, tlp_count);
        end
        run_cmd(64'h9000, 24'd300, 1'b1, 3'd1, 1, 0, -1);
    endtask

    initial begin
        test_reset();
        test_mps_split();
        test_4k_cross();
        test_carry_illegal_mps();
        test_backpressure();
        test_zero_count();
        test_cnt_clr_priority();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmawr_tlp_splitter.md
# dmawr_tlp_splitter

Splits each DMA write command (start address plus byte count) into a sequence of PCIe memory-write requests. Each request respects the programmed maximum payload size and never crosses a 4 KB address boundary. It sits between the dmawr line/command sequencer, which feeds it, and the TLP header/data formatter, which consumes its requests. It holds one command at a time and issues at most one request per clock.

## Interface
Parameters:
- ADDR_WIDTH, 64, host address width (bits)
- BCNT_WIDTH, 24, command byte-count width

Ports:
- sysclk  in  1  system clock; all logic on rising edge
- sysrst  in  1  asynchronous, active-high reset
- cfg_max_payload  in  3  0=128 B, 1=256 B, 2=512 B; any other value=128 B
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_addr  in  ADDR_WIDTH  start byte address; bits [1:0] are ignored (treated 0)
- cmd_bcnt  in  BCNT_WIDTH  byte count; bits [1:0] are ignored (DW granularity)
- cmd_eof  in  1  command closes a frame; forwarded on the last request
- req_valid  out  1  request present
- req_ready  in  1  request consumed when req_valid && req_ready
- req_addr  out  ADDR_WIDTH  request start address (DW aligned)
- req_dwcnt  out  8  request length in DWORDs, range 1..128
- req_first  out  1  first request of the command
- req_last  out  1  last request of the command
- req_eof  out  1  req_last && the cmd_eof captured with the command
- busy  out  1  command in progress
- err_zero_bcnt  out  1  sticky; cleared by cnt_clr
- tlp_count  out  32  number of requests issued (handshakes); wraps
- cnt_clr  in  1  synchronous clear of tlp_count and err_zero_bcnt

## Operation
- State machine has two states, IDLE and SPLIT. All outputs are registered.
- **IDLE:**
  - cmd_ready=1.
  - On a handshake with DW count ≠ 0: capture addr, remaining DW count, eof and the decoded max payload (mps_dw = 32/64/128). Go to SPLIT.
  - On a handshake with DW count = 0 (bcnt < 4): set err_zero_bcnt, issue no request, stay in IDLE.
- **SPLIT:**
  - cmd_ready=0, busy=1.
  - Chunk = min(remaining_dw, mps_dw, (4096 − addr[11:0])/4).
  - The chunk is computed combinationally from captured state and loaded into req_* registers.
  - On a request handshake: addr += chunk×4 (full ADDR_WIDTH carry), remaining −= chunk.
  - When the handshake carries req_last: return to IDLE.
- Request flags:
  - req_first is set only on the first request after command capture.
  - req_last is set when chunk == remaining.
  - A command that fits in one request has req_first=req_last=1.
- cfg_max_payload is sampled only at command capture. Changing it mid-command has no effect on that command.
- tlp_count increments on every request handshake.
- cnt_clr has priority over an increment in the same cycle; the counter goes to 0 and the increment is lost.
- cnt_clr has priority over a zero-count set in the same cycle.
- Remaining width is BCNT_WIDTH−2. The 4 KB gap is computed in 11 bits (1..1024 DW) and then limited by mps.

## Timing
- Reset values: cmd_ready=0 during reset and 1 on the first cycle after release. req_valid=0, req_addr=0, req_dwcnt=0, req_first/last/eof=0, busy=0, err_zero_bcnt=0, tlp_count=0.
- Command handshake at cycle T gives req_valid=1 at T+1, with the first request's fields valid.
- While req_ready=1 the block issues one request per cycle, back-to-back with no bubbles.
- When the last request handshakes at cycle L: req_valid=0 and cmd_ready=1 at L+1. The next command handshaking at L+1 gives its first request at L+2.
- While req_valid=1 and req_ready=0, all req_* outputs hold stable. req_valid never drops without a handshake.
- Asserting sysrst mid-command returns all outputs to reset values immediately. The partial command is discarded and no further requests are issued after release.
- Zero-count command: err_zero_bcnt=1 at T+1, and cmd_ready stays 1 throughout.

## Test plan
1. mps=1, addr 0x1000, bcnt 1024 → 4 requests at 0x1000/0x1100/0x1200/0x1300, each 64 DW. first on #1 only, last on #4 only. tlp_count=4.
2. 4 KB crossing: mps=2, addr 0x0FC0, bcnt 256, eof=1 → 0x0FC0/16 DW (first), then 0x1000/48 DW (last, eof=1).
3. 32-bit carry and illegal mps: mps=3, addr 0x0_FFFF_FF80, bcnt 256 → 0x0_FFFF_FF80/32 DW, then 0x1_0000_0000/32 DW.
4. Backpressure: req_ready=0 for 5 cycles after the first req_valid → req fields unchanged for 5 cycles. Sequence completes identically once req_ready=1.
5. Zero-count: bcnt 3 → no req_valid, err_zero_bcnt=1 at T+1, cmd_ready stays 1. cnt_clr → err_zero_bcnt=0, tlp_count=0.
6. Reset mid-command: 2048 B at mps=0, sysrst asserted after 3 handshakes → all outputs at reset values. No req_valid after release until a new command is handshaked.
